iq_decim_avg: RTL and testbench

// - Downstream stage of the 15-tap IQ low-pass FIR in the VNA receive chain.
// - Takes the filtered packed-IQ AXI-Stream and averages non-overlapping blocks of 2**LOG2_DECIM

---
 rtl/iq_pkg.sv | 8 +
 rtl/iq_accum.sv | 17 +
 rtl/iq_decim_avg.sv | 66 ++++++
 tb/tb_iq_decim_avg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// iq_pkg: shared IQ sample type and rail width for the decimating averager
package iq_pkg;
    localparam int IQ_W = 16;
    typedef struct packed {
        logic signed [IQ_W-1:0] re;
        logic signed [IQ_W-1:0] im;
    } iq_t;
endpackage

// File: rtl/iq_accum.sv
// iq_accum: signed block accumulator for one IQ rail, wide enough that a full block never overflows
import iq_pkg::*;
module iq_accum #(
    parameter int LOG2_DECIM = 4
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic                               en,
    input  logic                               clr,
    input  logic signed [IQ_W-1:0]             din,
    output logic signed [IQ_W+LOG2_DECIM-1:0]  sum
);
    always_ff @(posedge clk or posedge areset)
        if (areset) sum <= '0;
        else if (clr) sum <= '0;
        else if (en) sum <= sum + (IQ_W+LOG2_DECIM)'(din);
endmodule

// File: rtl/iq_decim_avg.sv
// iq_decim_avg: averages non-overlapping blocks of 2**LOG2_DECIM packed IQ samples, flushing short blocks on tlast
import iq_pkg::*;
module iq_decim_avg #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_DECIM             = 4,
    parameter int FCNT_W                 = 16
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                                  m00_axis_tready,
    output logic [FCNT_W-1:0]                     frame_count
);
    localparam int AW    = IQ_W + LOG2_DECIM;
    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int CW    = LOG2_DECIM == 0 ? 1 : LOG2_DECIM;
    iq_t                  s_iq;
    logic                 acc;
    logic                 close;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] sum_re, sum_im, tot_re, tot_im;
    assign s_iq            = s00_axis_tdata;
    assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
    assign m00_axis_tstrb  = '1;
    assign acc             = s00_axis_tvalid && s00_axis_tready;
    assign close           = s00_axis_tlast || cnt == CW'(DECIM - 1);
    // The closing sample is folded in combinationally so the block closes without an input bubble
    assign tot_re          = sum_re + AW'(s_iq.re);
    assign tot_im          = sum_im + AW'(s_iq.im);
    iq_accum #(.LOG2_DECIM(LOG2_DECIM)) u_acc_re (
        .clk(s00_axis_aclk), .areset(s00_axis_areset), .en(acc), .clr(acc && close),
        .din(s_iq.re), .sum(sum_re)
    );
    iq_accum #(.LOG2_DECIM(LOG2_DECIM)) u_acc_im (
        .clk(s00_axis_aclk), .areset(s00_axis_areset), .en(acc), .clr(acc && close),
        .din(s_iq.im), .sum(sum_im)
    );
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset)
        if (s00_axis_areset) cnt <= '0;
        else if (acc) cnt <= close ? '0 : cnt + 1'b1;
    // Fixed shift even for short blocks: output is sum/2**LOG2_DECIM, floored
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset)
        if (s00_axis_areset) begin
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
        end else if (acc && close) begin
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'({IQ_W'(tot_re >>> LOG2_DECIM), IQ_W'(tot_im >>> LOG2_DECIM)});
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= s00_axis_tlast;
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
        end
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset)
        if (s00_axis_areset) frame_count <= '0;
        else if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) frame_count <= frame_count + 1'b1;
endmodule

// File: tb/tb_iq_decim_avg.sv
// tb_iq_decim_avg: directed and randomized checks of the IQ block averager against a floor-division block model
module tb_iq_decim_avg;
    localparam int L  = 4;
    localparam int D  = 1 << L;
    localparam int FW = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0]   m_data;
    logic          m_valid, m_last, m_ready;
    logic [3:0]    m_strb;
    logic [FW-1:0] fc;
    logic          ready_dir = 1'b1, bp_en = 1'b0, bp_bit = 1'b1;

    int chks = 0, errs = 0, cchks = 0, cerrs = 0;

    assign m_ready = bp_en ? bp_bit : ready_dir;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        bp_bit = ($urandom % 3) != 0;
    end

    iq_decim_avg #(
        .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .LOG2_DECIM(L), .FCNT_W(FW)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tdata(s_data), .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tready(s_ready),
        .m00_axis_tdata(m_data), .m00_axis_tvalid(m_valid), .m00_axis_tlast(m_last), .m00_axis_tstrb(m_strb),
        .m00_axis_tready(m_ready), .frame_count(fc)
    );

    // Reference: average = floor(sum / D) of the samples in the block, per rail
    int            bre[$], bim[$];
    logic [31:0]   expd[$];
    logic          expl[$];
    logic [FW-1:0] fc_mod = '0;
    logic          pend = 1'b0, pl = 1'b0;
    logic [31:0]   pd = '0;

    function automatic logic [15:0] favg(input int s);
        int q;
        q = s / D;
        if (s % D != 0 && s < 0) q = q - 1;
        return 16'(q);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            bre.delete(); bim.delete(); expd.delete(); expl.delete();
            fc_mod = '0;
            pend = 1'b0;
        end else begin
            cchks++;
            assert (s_ready === (!m_valid || m_ready)) else begin
                cerrs++; $error("FAIL s_ready got %b want %b", s_ready, !m_valid || m_ready);
            end
            cchks++;
            assert (fc === fc_mod) else begin
                cerrs++; $error("FAIL frame_count got %0d want %0d", fc, fc_mod);
            end
            if (pend) begin
                cchks++;
                assert (m_valid === 1'b1 && m_data === pd && m_last === pl) else begin
                    cerrs++; $error("FAIL latency got v=%b d=%h l=%b want v=1 d=%h l=%b", m_valid, m_data, m_last, pd, pl);
                end
                pend = 1'b0;
            end
            if (m_valid && m_ready) begin
                cchks++;
                if (expd.size() == 0) begin
                    cerrs++; $error("FAIL out_extra got %h want no output", m_data);
                end else begin
                    assert ({m_data, m_last} === {expd[0], expl[0]}) else begin
                        cerrs++; $error("FAIL out_data got %h/%b want %h/%b", m_data, m_last, expd[0], expl[0]);
                    end
                    if (expl[0]) fc_mod = fc_mod + 1'b1;
                    void'(expd.pop_front());
                    void'(expl.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                bre.push_back(int'($signed(s_data[31:16])));
                bim.push_back(int'($signed(s_data[15:0])));
                if (bre.size() == D || s_last) begin
                    int sr, si;
                    sr = 0; si = 0;
                    foreach (bre[i]) begin sr += bre[i]; si += bim[i]; end
                    pd = {favg(sr), favg(si)};
                    pl = s_last;
                    expd.push_back(pd);
                    expl.push_back(pl);
                    pend = 1'b1;
                    bre.delete(); bim.delete();
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        chks++;
        assert (got === want) else begin
            errs++; $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic send(input int re, input int im, input logic last);
        int n;
        n = 0;
        s_data = {16'(re), 16'(im)};
        s_valid = 1'b1;
        s_last = last;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chks++;
        assert (n < 300) else begin
            errs++; $error("FAIL send_timeout got %0d cycles want under 300", n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] fc0;
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_data", m_data, 0);
        chk("rst_fc", 32'(fc), 0);
        chk("tstrb", 32'(m_strb), 32'hF);
        rst = 1'b0;
        repeat (7) send(100, -100, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(m_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) send(100, -100, 1'b0);
        chk("t1_no_early", 32'(m_valid), 0);
        send(100, -100, 1'b0);
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_data", m_data, 32'h0064FF9C);
        for (int i = 1; i <= 32; i++) begin
            send(1000, -1000, 1'b0);
            if (i % 16 == 0) begin
                chk("const_valid", 32'(m_valid), 1);
                chk("const_data", m_data, 32'h03E8FC18);
            end
        end
        for (int i = 0; i < 16; i++) send(i, -1, 1'b0);
        chk("ramp_data", m_data, 32'h0007FFFF);
        fc0 = fc;
        for (int i = 1; i <= 20; i++) begin
            send(160, 160, i == 20);
            if (i == 16) begin
                chk("frame_full", m_data, 32'h00A000A0);
                chk("frame_full_last", 32'(m_last), 0);
            end
        end
        chk("frame_short", m_data, 32'h00280028);
        chk("frame_short_last", 32'(m_last), 1);
        @(posedge clk);
        #1;
        chk("frame_count", 32'(fc), 32'(FW'(fc0 + 1'b1)));
        ready_dir = 1'b0;
        repeat (16) send(500, -300, 1'b0);
        chk("bp_first", m_data, 32'h01F4FED4);
        s_data = {16'hFFF9, 16'h0003};
        s_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", m_data, 32'h01F4FED4);
            chk("bp_hold_valid", 32'(m_valid), 1);
            chk("bp_sready", 32'(s_ready), 0);
        end
        ready_dir = 1'b1;
        repeat (16) send(-7, 3, 1'b0);
        chk("bp_next", m_data, 32'hFFF90003);
        repeat (16) send(32, 32, 1'b0);
        chk("sim_first", m_data, 32'h00200020);
        send(16, -16, 1'b1);
        chk("sim_valid", 32'(m_valid), 1);
        chk("sim_data", m_data, 32'h0001FFFF);
        chk("sim_last", 32'(m_last), 1);
        @(posedge clk);
        #1;
        chk("sim_drop", 32'(m_valid), 0);
        send(-1, -17, 1'b1);
        chk("floor_short", m_data, 32'hFFFFFFFE);
        bp_en = 1'b1;
        repeat (400) begin
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), ($urandom % 10) == 0);
            k = $urandom % 3;
            repeat (k) begin
                @(posedge clk);
                #1;
            end
        end
        bp_en = 1'b0;
        ready_dir = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain", 32'(expd.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", chks + cchks, errs + cerrs);
        $finish;
    end
endmodule
